// File: rtl/topk_insertion_sorter_pkg.sv
// ============================================================
// Module : topk_insertion_sorter_pkg
// FSM encodings and compare helper shared by the top-K sorter.
// Rev    : 1.0
// ============================================================
`default_nettype none

package topk_insertion_sorter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_fill  = 2'd1;
    localparam state_t c_st_drain = 2'd2;

    // Strict ordering: an equal key never beats, so earlier arrivals stay ahead.
    function automatic logic beats(input logic ascend, input logic lt, input logic gt);
        return ascend ? lt : gt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/topk_insertion_sorter_if.sv
// ============================================================
// Module : topk_insertion_sorter_if
// Input stream, result stream and status of the top-K sorter.
// Rev    : 1.0
// ============================================================
`default_nettype none

interface topk_insertion_sorter_if #(
    parameter int NAME_W  = 32,
    parameter int VALUE_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [NAME_W-1:0]  in_name;
    logic [VALUE_W-1:0] in_value;
    logic               in_last;
    logic [31:0]        k;
    logic               out_valid;
    logic               out_ready;
    logic [NAME_W-1:0]  out_name;
    logic [VALUE_W-1:0] out_value;
    logic               out_last;
    logic               busy;

    modport slave (
        input  in_valid, in_name, in_value, in_last, k, out_ready,
        output in_ready, out_valid, out_name, out_value, out_last, busy
    );

    modport master (
        output in_valid, in_name, in_value, in_last, k, out_ready,
        input  in_ready, out_valid, out_name, out_value, out_last, busy
    );
endinterface

`default_nettype wire

// File: rtl/topk_insertion_sorter_slot.sv
// ============================================================
// Module : topk_insertion_sorter_slot
// One cell of the sort chain: loads new item, predecessor or successor.
// Rev    : 1.0
// ============================================================
`default_nettype none

module topk_insertion_sorter_slot
    import topk_insertion_sorter_pkg::*;
#(
    parameter int NAME_W  = 32,
    parameter int VALUE_W = 32,
    parameter bit ASCEND  = 1'b1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               i_clear,
    input  wire logic               i_ins_en,
    input  wire logic               i_shift_en,
    input  wire logic [NAME_W-1:0]  i_new_name,
    input  wire logic [VALUE_W-1:0] i_new_value,
    input  wire logic               i_prev_beaten,
    input  wire logic               i_prev_valid,
    input  wire logic [NAME_W-1:0]  i_prev_name,
    input  wire logic [VALUE_W-1:0] i_prev_value,
    input  wire logic               i_next_valid,
    input  wire logic [NAME_W-1:0]  i_next_name,
    input  wire logic [VALUE_W-1:0] i_next_value,
    output logic                    o_beaten,
    output logic                    o_valid,
    output logic [NAME_W-1:0]       o_name,
    output logic [VALUE_W-1:0]      o_value
);

    logic               r_valid;
    logic [NAME_W-1:0]  r_name;
    logic [VALUE_W-1:0] r_value;
    logic               w_lt;
    logic               w_gt;

    assign w_lt     = i_new_value < r_value;
    assign w_gt     = i_new_value > r_value;
    assign o_beaten = !r_valid || beats(ASCEND, w_lt, w_gt);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_valid <= 1'b0;
            r_name  <= '0;
            r_value <= '0;
        end else if (i_ins_en) begin
            // Predecessor displaced means everything from here down moves one step.
            if (i_prev_beaten) begin
                r_valid <= i_prev_valid;
                r_name  <= i_prev_name;
                r_value <= i_prev_value;
            end else if (o_beaten) begin
                r_valid <= 1'b1;
                r_name  <= i_new_name;
                r_value <= i_new_value;
            end
        end else if (i_shift_en) begin
            r_valid <= i_next_valid;
            r_name  <= i_next_name;
            r_value <= i_next_value;
        end
    end

    assign o_valid = r_valid;
    assign o_name  = r_name;
    assign o_value = r_value;

endmodule

`default_nettype wire

// File: rtl/topk_insertion_sorter.sv
// ============================================================
// Module : topk_insertion_sorter
// Streaming top-K selector: insertion-sort chain, sorted valid/ready drain.
// Rev    : 1.0
// ============================================================
`default_nettype none

module topk_insertion_sorter
    import topk_insertion_sorter_pkg::*;
#(
    parameter int NAME_W  = 32,
    parameter int VALUE_W = 32,
    parameter int K_MAX   = 16,
    parameter bit ASCEND  = 1'b1
) (
    input  wire logic                clk,
    input  wire logic                reset,
    topk_insertion_sorter_if.slave   bus
);

    localparam int          c_cnt_w  = $clog2(K_MAX + 1);
    localparam logic [31:0] c_kmax32 = 32'(K_MAX);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] r_k_q;
    logic [c_cnt_w-1:0] w_k_in;
    logic [c_cnt_w-1:0] w_k_eff;

    logic w_in_ready;
    logic w_out_valid;
    logic w_out_last;
    logic w_busy;
    logic w_accept;
    logic w_out_hs;
    logic w_ins_en;
    logic w_shift_en;
    logic w_clear;

    // Index 0 and K_MAX+1 are the empty neighbours of the chain ends; slot i sits at i+1.
    logic               w_s_valid [K_MAX+2];
    logic [NAME_W-1:0]  w_s_name  [K_MAX+2];
    logic [VALUE_W-1:0] w_s_value [K_MAX+2];
    logic               w_beaten  [K_MAX+1];

    assign w_s_valid[0]       = 1'b0;
    assign w_s_name[0]        = '0;
    assign w_s_value[0]       = '0;
    assign w_s_valid[K_MAX+1] = 1'b0;
    assign w_s_name[K_MAX+1]  = '0;
    assign w_s_value[K_MAX+1] = '0;
    assign w_beaten[0]        = 1'b0;

    generate
        for (genvar gi = 0; gi < K_MAX; gi++) begin : g_slot
            topk_insertion_sorter_slot #(
                .NAME_W  (NAME_W),
                .VALUE_W (VALUE_W),
                .ASCEND  (ASCEND)
            ) u_slot (
                .clk           (clk),
                .reset         (reset),
                .i_clear       (w_clear),
                .i_ins_en      (w_ins_en),
                .i_shift_en    (w_shift_en),
                .i_new_name    (bus.in_name),
                .i_new_value   (bus.in_value),
                .i_prev_beaten (w_beaten[gi]),
                .i_prev_valid  (w_s_valid[gi]),
                .i_prev_name   (w_s_name[gi]),
                .i_prev_value  (w_s_value[gi]),
                .i_next_valid  (w_s_valid[gi+2]),
                .i_next_name   (w_s_name[gi+2]),
                .i_next_value  (w_s_value[gi+2]),
                .o_beaten      (w_beaten[gi+1]),
                .o_valid       (w_s_valid[gi+1]),
                .o_name        (w_s_name[gi+1]),
                .o_value       (w_s_value[gi+1])
            );
        end
    endgenerate

    always_comb begin
        if (bus.k == 32'd0)
            w_k_in = c_cnt_w'(1);
        else if (bus.k > c_kmax32)
            w_k_in = c_cnt_w'(K_MAX);
        else
            w_k_in = bus.k[c_cnt_w-1:0];
    end

    // The first accept of a set must see the k being latched in that same cycle.
    assign w_k_eff  = (r_state == c_st_idle) ? w_k_in : r_k_q;
    assign w_accept = bus.in_valid && w_in_ready;
    assign w_out_hs = w_out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= c_st_idle;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept)
                    w_state_nxt = bus.in_last ? c_st_drain : c_st_fill;
            end
            c_st_fill: begin
                if (w_accept && bus.in_last)
                    w_state_nxt = c_st_drain;
            end
            c_st_drain: begin
                if (w_out_hs && w_out_last)
                    w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state != c_st_drain);
        w_out_valid = (r_state == c_st_drain);
        w_busy      = (r_state != c_st_idle);
        w_out_last  = (r_state == c_st_drain) && (r_count == c_cnt_w'(1));
        w_ins_en    = w_accept;
        w_shift_en  = w_out_hs && !w_out_last;
        w_clear     = w_out_hs && w_out_last;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_k_q <= '0;
        else if (r_state == c_st_idle && w_accept)
            r_k_q <= w_k_in;
    end

    always_ff @(posedge clk) begin
        if (reset || w_clear)
            r_count <= '0;
        else if (w_shift_en)
            r_count <= r_count - c_cnt_w'(1);
        else if (w_accept && r_count < w_k_eff)
            r_count <= r_count + c_cnt_w'(1);
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_out_last;
    assign bus.busy      = w_busy;
    assign bus.out_name  = w_s_name[1];
    assign bus.out_value = w_s_value[1];

endmodule

`default_nettype wire
